// File: rtl/spi1_pkg.sv
// Shared definitions for the SPI1 controller.
// Contents: controller FSM state type and the byte width of the link.
package spi1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWaitRdy,
        StShiftLo,
        StShiftHi,
        StGap,
        StHold
    } spi1_ctl_state_t;

    localparam int unsigned SPI1_BYTE_BITS = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, loads ResetVal into both flops
//   d_i   - asynchronous input
//   q_o   - synchronised output, two clk_i cycles behind d_i
module sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi1_controller.sv
// SPI mode-0 initiator for the SPI1 link.
// Takes bytes over a valid/ready interface, frames them with CS_n (held low across
// multi-byte transactions until a byte marked last), waits for the target's active-low
// ready before every byte, shifts MSB first and returns the byte shifted in from POCI.
// Ports:
//   clk16_i, reset_i           - clock and synchronous active-high reset
//   tx_data_i/last_i/valid_i   - byte to send, end-of-transaction flag, offer
//   tx_ready_o                 - byte accepted when tx_valid_i & tx_ready_o
//   rx_data_o, rx_valid_o      - received byte and its one-cycle strobe
//   busy_o                     - controller not idle
//   spi_sck_o/cs_no/pico_o     - SPI outputs (CPOL=0, CS active-low)
//   spi_poci_i, spi_ready_ni   - SPI inputs; ready is asynchronous
module spi1_controller
    import spi1_pkg::*;
#(
    parameter int unsigned SCK_DIV  = 2,
    parameter int unsigned CS_SETUP = 2
) (
    input  logic       clk16_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_cs_no,
    output logic       spi_pico_o,
    input  logic       spi_poci_i,
    input  logic       spi_ready_ni
);

    localparam logic [7:0] DivLoad   = 8'(SCK_DIV - 1);
    localparam logic [7:0] SetupLoad = 8'(CS_SETUP);
    localparam logic [7:0] HoldLoad  = 8'(CS_SETUP - 1);
    localparam logic [2:0] LastBit   = 3'(SPI1_BYTE_BITS - 1);

    spi1_ctl_state_t state_q;
    logic [7:0]      cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      tx_shift_q;
    logic [7:0]      rx_shift_q;
    logic            last_q;
    logic            sck_q;
    logic            cs_n_q;
    logic            pico_q;
    logic            tx_ready_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            busy_q;

    logic ready_n_sync;
    logic accept;

    sync2 #(
        .ResetVal(1'b1)
    ) u_ready_sync (
        .clk_i(clk16_i),
        .rst_i(reset_i),
        .d_i  (spi_ready_ni),
        .q_o  (ready_n_sync)
    );

    assign accept = tx_valid_i & tx_ready_q;

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            pico_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_shift_q <= tx_data_i;
                        last_q     <= tx_last_i;
                        pico_q     <= tx_data_i[7];
                        cs_n_q     <= 1'b0;
                        cnt_q      <= SetupLoad;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StSetup;
                    end
                end
                // Counts down through zero, so CS_SETUP+1 cycles elapse before the
                // ready check; with ready already low, accept to rx_valid_o is
                // CS_SETUP + 2 + 16*SCK_DIV.
                StSetup: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StWaitRdy;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StWaitRdy: begin
                    if (!ready_n_sync) begin
                        cnt_q   <= DivLoad;
                        bit_q   <= 3'd0;
                        state_q <= StShiftLo;
                    end
                end
                StShiftLo: begin
                    if (cnt_q == 8'd0) begin
                        sck_q      <= 1'b1;
                        rx_shift_q <= {rx_shift_q[6:0], spi_poci_i};
                        cnt_q      <= DivLoad;
                        state_q    <= StShiftHi;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StShiftHi: begin
                    if (cnt_q == 8'd0) begin
                        sck_q <= 1'b0;
                        cnt_q <= DivLoad;
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == LastBit) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (last_q) begin
                                cnt_q   <= HoldLoad;
                                state_q <= StHold;
                            end else begin
                                tx_ready_q <= 1'b1;
                                state_q    <= StGap;
                            end
                        end else begin
                            // Rotate so the next bit to send always sits at [7] after
                            // the update; PICO takes it now, on the SCK fall.
                            tx_shift_q <= {tx_shift_q[6:0], tx_shift_q[7]};
                            pico_q     <= tx_shift_q[6];
                            state_q    <= StShiftLo;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (accept) begin
                        tx_shift_q <= tx_data_i;
                        last_q     <= tx_last_i;
                        pico_q     <= tx_data_i[7];
                        tx_ready_q <= 1'b0;
                        state_q    <= StWaitRdy;
                    end
                end
                StHold: begin
                    if (cnt_q == 8'd0) begin
                        cs_n_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign spi_sck_o  = sck_q;
    assign spi_cs_no  = cs_n_q;
    assign spi_pico_o = pico_q;

endmodule

// File: tb/tb_spi1_controller.sv
// Directed bench for spi1_controller: a scoreboard queue holds expected rx bytes,
// pushed when a byte is offered and popped on every rx_valid_o pulse. A second
// instance runs with SCK_DIV=1 to check the fastest clock setting.
module tb_spi1_controller;

    localparam int unsigned SckDiv   = 2;
    localparam int unsigned CsSetup  = 2;
    localparam int unsigned SckDivB  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       cs_n;
    logic       pico;
    logic       poci;
    logic       ready_n;
    logic       loop;

    // Instance B signals
    logic [7:0] b_tx_data;
    logic       b_tx_last;
    logic       b_tx_valid;
    logic       b_tx_ready;
    logic [7:0] b_rx_data;
    logic       b_rx_valid;
    logic       b_busy;
    logic       b_sck;
    logic       b_cs_n;
    logic       b_pico;
    logic       b_ready_n;

    // Target model state
    logic [7:0] tgt_byte;
    logic [7:0] tgt_tx = 8'h00;
    logic [7:0] tgt_rx = 8'h00;

    assign poci = loop ? pico : tgt_tx[7];

    spi1_controller #(
        .SCK_DIV (SckDiv),
        .CS_SETUP(CsSetup)
    ) dut (
        .clk16_i     (clk),
        .reset_i     (reset),
        .tx_data_i   (tx_data),
        .tx_last_i   (tx_last),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .busy_o      (busy),
        .spi_sck_o   (sck),
        .spi_cs_no   (cs_n),
        .spi_pico_o  (pico),
        .spi_poci_i  (poci),
        .spi_ready_ni(ready_n)
    );

    spi1_controller #(
        .SCK_DIV (SckDivB),
        .CS_SETUP(CsSetup)
    ) dut_b (
        .clk16_i     (clk),
        .reset_i     (reset),
        .tx_data_i   (b_tx_data),
        .tx_last_i   (b_tx_last),
        .tx_valid_i  (b_tx_valid),
        .tx_ready_o  (b_tx_ready),
        .rx_data_o   (b_rx_data),
        .rx_valid_o  (b_rx_valid),
        .busy_o      (b_busy),
        .spi_sck_o   (b_sck),
        .spi_cs_no   (b_cs_n),
        .spi_pico_o  (b_pico),
        .spi_poci_i  (b_pico),
        .spi_ready_ni(b_ready_n)
    );

    logic [7:0] exp_q[$];
    logic [7:0] exp_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor for instance A (also runs the target model)
    int   sck_rises = 0;
    int   cs_low = 0;
    int   cs_rises = 0;
    int   gap_cnt = 0;
    int   rx_pulses = 0;
    int   last_rise_cyc = 0;
    int   last_rx_cyc = 0;
    logic sck_prev = 1'b0;
    logic cs_prev = 1'b1;

    always @(negedge clk) begin
        logic rose, fell;
        rose = sck && !sck_prev;
        fell = !sck && sck_prev;
        if (rose) begin
            sck_rises++;
            last_rise_cyc = cyc;
            tgt_rx = {tgt_rx[6:0], pico};
        end
        if (fell) tgt_tx = {tgt_tx[6:0], 1'b0};
        if (!cs_n && cs_prev) begin
            tgt_tx = tgt_byte;
            tgt_rx = 8'h00;
        end
        sck_prev = sck;
        if (!cs_n) cs_low++;
        if (cs_n && !cs_prev) cs_rises++;
        cs_prev = cs_n;
        if (tx_ready && !reset) begin
            check("ready_sck_low", 32'(sck), 32'd0);
            if (!cs_n) begin
                gap_cnt++;
                check("gap_with_rx", 32'(rx_valid), 32'd1);
            end
        end
        if (rx_valid) begin
            rx_pulses++;
            last_rx_cyc = cyc;
            check("rx_queue", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    // Monitor for instance B
    int   b_rises = 0;
    int   b_pulses = 0;
    int   b_r1 = 0;
    int   b_r2 = 0;
    int   b_rx1 = 0;
    logic b_prev = 1'b0;

    always @(negedge clk) begin
        if (b_sck && !b_prev) begin
            b_rises++;
            if (b_rises == 1) b_r1 = cyc;
            if (b_rises == 2) b_r2 = cyc;
        end
        b_prev = b_sck;
        if (b_rx_valid) begin
            b_pulses++;
            if (b_pulses == 1) b_rx1 = cyc;
            check("b_rx_queue", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) check("b_rx_data", 32'(b_rx_data), 32'(exp_b.pop_front()));
        end
    end

    int acc_cyc = 0;

    // Offer a byte on A; caller is at a negedge. Returns at the negedge after accept.
    task automatic send_a(input logic [7:0] d, input logic last, input logic [7:0] exp,
                          input bit push);
        int n;
        n = 0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_a", 32'(tx_ready), 32'd1);
        @(negedge clk);
        acc_cyc  = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        b_tx_data  = d;
        b_tx_last  = last;
        b_tx_valid = 1'b1;
        exp_b.push_back(d);
        while (!b_tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_b", 32'(b_tx_ready), 32'd1);
        @(negedge clk);
        b_tx_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_a", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rises, base_low, base_rx, base_gap, base_csr, bad, fall_cyc, n;

        reset      = 1'b1;
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        tx_valid   = 1'b0;
        ready_n    = 1'b0;
        loop       = 1'b1;
        tgt_byte   = 8'h00;
        b_tx_data  = 8'h00;
        b_tx_last  = 1'b0;
        b_tx_valid = 1'b0;
        b_ready_n  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_pico", 32'(pico), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback single byte 0xA5
        base_rises = sck_rises;
        base_low   = cs_low;
        base_rx    = rx_pulses;
        send_a(8'hA5, 1'b1, 8'hA5, 1'b1);
        wait_idle_a();
        check("lb_sck_rises", 32'(sck_rises - base_rises), 32'd8);
        check("lb_cs_low", 32'(cs_low - base_low), 32'(2 * CsSetup + 2 + 16 * SckDiv));
        check("lb_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
        check("lb_latency", 32'(last_rx_cyc - acc_cyc), 32'(CsSetup + 2 + 16 * SckDiv));
        check("lb_queue_empty", 32'(exp_q.size()), 32'd0);

        // Target model returns 0x3C while 0xC3 is sent
        loop     = 1'b0;
        tgt_byte = 8'h3C;
        @(negedge clk);
        send_a(8'hC3, 1'b1, 8'h3C, 1'b1);
        wait_idle_a();
        check("tgt_captured", 32'(tgt_rx), 32'hC3);
        check("tgt_queue_empty", 32'(exp_q.size()), 32'd0);
        loop = 1'b1;
        @(negedge clk);

        // Three-byte transaction with back-to-back offers
        base_rises = sck_rises;
        base_rx    = rx_pulses;
        base_gap   = gap_cnt;
        base_csr   = cs_rises;
        send_a(8'h01, 1'b0, 8'h01, 1'b1);
        send_a(8'h02, 1'b0, 8'h02, 1'b1);
        send_a(8'h03, 1'b1, 8'h03, 1'b1);
        wait_idle_a();
        check("multi_rx_pulses", 32'(rx_pulses - base_rx), 32'd3);
        check("multi_sck_rises", 32'(sck_rises - base_rises), 32'd24);
        check("multi_cs_rises", 32'(cs_rises - base_csr), 32'd1);
        check("multi_gap_cycles", 32'(gap_cnt - base_gap), 32'd2);
        check("multi_queue_empty", 32'(exp_q.size()), 32'd0);

        // Target holds ready_n high for 50 cycles
        ready_n = 1'b1;
        repeat (4) @(negedge clk);
        base_rises = sck_rises;
        send_a(8'h96, 1'b1, 8'h96, 1'b1);
        repeat (CsSetup + 1) @(negedge clk);
        bad = 0;
        repeat (50) begin
            if (sck || cs_n) bad++;
            @(negedge clk);
        end
        check("wait_sck_cs", 32'(bad), 32'd0);
        check("wait_no_rise", 32'(sck_rises - base_rises), 32'd0);
        ready_n  = 1'b0;
        fall_cyc = cyc;
        n = 0;
        while (sck_rises == base_rises && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_rise_seen", 32'(sck_rises != base_rises), 32'd1);
        // fall_cyc+1 is the first edge that samples the falling ready_n
        check("wait_first_rise", 32'(last_rise_cyc - (fall_cyc + 1)), 32'(2 + SckDiv));
        wait_idle_a();
        check("wait_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after four SCK rises; partial byte is discarded
        base_rises = sck_rises;
        base_rx    = rx_pulses;
        send_a(8'hE7, 1'b1, 8'h00, 1'b0);
        n = 0;
        while (sck_rises - base_rises < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_rise4_seen", 32'(sck_rises - base_rises), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_sck", 32'(sck), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_rst_no_rx", 32'(rx_pulses - base_rx), 32'd0);
        send_a(8'h5A, 1'b1, 8'h5A, 1'b1);
        wait_idle_a();
        check("post_rst_rx", 32'(rx_pulses - base_rx), 32'd1);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // SCK_DIV=1 instance, back-to-back bytes
        send_b(8'h81, 1'b0);
        send_b(8'h7E, 1'b1);
        n = 0;
        while (b_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b_idle", 32'(b_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("b_sck_period", 32'(b_r2 - b_r1), 32'(2 * SckDivB));
        check("b_byte_time", 32'(b_rx1 - b_r1 + SckDivB), 32'(16 * SckDivB));
        check("b_rx_pulses", 32'(b_pulses), 32'd2);
        check("b_queue_empty", 32'(exp_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
